// File: rtl/amm_pkg.sv
// Shared widths, constants and the byte-merge helper for the Avalon-MM slave memory.
package amm_pkg;

  localparam int DATAWIDTH      = 32;
  localparam int ADDRESSWIDTH   = 28;
  localparam int BYTES_PER_WORD = DATAWIDTH / 8;

  localparam logic [DATAWIDTH-1:0] OOB_READ_PATTERN = 32'hDEADBEEF;

  function automatic logic [DATAWIDTH-1:0] merge_bytes(
    input logic [DATAWIDTH-1:0]      old_word,
    input logic [DATAWIDTH-1:0]      new_word,
    input logic [BYTES_PER_WORD-1:0] be
  );
    logic [DATAWIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/amm_slave_mem_if.sv
// Avalon-MM slave bus bundle. Handshake: a request (read or write) is accepted in a cycle
// where it is asserted and waitrequest is low; otherwise the master holds it unchanged.
interface amm_slave_mem_if;

  logic [amm_pkg::ADDRESSWIDTH-1:0]   avs_address;
  logic                               avs_read;
  logic                               avs_write;
  logic [amm_pkg::DATAWIDTH-1:0]      avs_writedata;
  logic [amm_pkg::BYTES_PER_WORD-1:0] avs_byteenable;
  logic                               avs_waitrequest;
  logic [amm_pkg::DATAWIDTH-1:0]      avs_readdata;
  logic                               avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/amm_rd_pipe.sv
// Fixed-latency read return path: a LATENCY-deep valid/data shift register.
module amm_rd_pipe
  import amm_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [DATAWIDTH-1:0] i_data,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] o_data
);

  logic [LATENCY-1:0]   r_valid;
  logic [DATAWIDTH-1:0] r_data [LATENCY];

  // Reset clears the valids so in-flight reads are discarded, never replayed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/amm_slave_mem.sv
// Avalon-MM slave backed by word-addressed on-chip RAM: byte-enabled writes, fixed-latency
// pipelined reads, programmable stall injection, sticky error flags and transfer counters.
module amm_slave_mem
  import amm_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2,
  parameter int STALL_EVERY  = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  amm_slave_mem_if.slave avs,
  input  logic           clear_stats,
  output logic [31:0]    wr_count,
  output logic [31:0]    rd_count,
  output logic           err_oob,
  output logic           err_proto
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [ADDRESSWIDTH-1:0] OOB_BASE = ADDRESSWIDTH'(DEPTH_WORDS * 4);

  logic [DATAWIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [PEND_W-1:0]    r_pending;
  logic [31:0]          r_wr_count;
  logic [31:0]          r_rd_count;
  logic                 r_err_oob;
  logic                 r_err_proto;

  logic                 w_oob;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_rd_only;
  logic [PEND_W-1:0]    w_pend_eff;
  logic                 w_stall_tick;
  logic                 w_wait;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_proto_acc;
  logic [DATAWIDTH-1:0] w_rd_data;
  logic                 w_rdv;
  logic [DATAWIDTH-1:0] w_rd_q;

  assign w_oob     = avs.avs_address >= OOB_BASE;
  assign w_idx     = avs.avs_address[IDX_W+1:2];
  assign w_rd_only = avs.avs_read & ~avs.avs_write;

  // A response leaving this cycle frees its slot, so a full pipe can still accept a read
  // in the same cycle; with one slot this gives the accept/stall alternation.
  assign w_pend_eff  = r_pending - PEND_W'(w_rdv);
  assign w_wait      = w_stall_tick | (w_rd_only & (w_pend_eff == PEND_W'(MAX_PENDING)));
  assign w_wr_acc    = avs.avs_write & ~w_wait;
  assign w_rd_acc    = w_rd_only & ~w_wait;
  assign w_proto_acc = avs.avs_read & avs.avs_write & ~w_wait;
  assign w_rd_data   = w_oob ? OOB_READ_PATTERN : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_oob) begin
      r_mem[w_idx] <= merge_bytes(r_mem[w_idx], avs.avs_writedata, avs.avs_byteenable);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      case ({w_rd_acc, w_rdv})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  generate
    if (STALL_EVERY == 0) begin : g_no_stall
      assign w_stall_tick = 1'b0;
    end else begin : g_stall
      localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
      logic [SW-1:0] r_stall_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stall_cnt <= '0;
        end else if (r_stall_cnt == SW'(STALL_EVERY - 1)) begin
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + SW'(1);
        end
      end

      assign w_stall_tick = (r_stall_cnt == SW'(STALL_EVERY - 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_oob   <= 1'b0;
      r_err_proto <= 1'b0;
    end else if (clear_stats) begin
      r_wr_count  <= '0;
      r_rd_count  <= '0;
      r_err_oob   <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
      if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
      if ((w_wr_acc || w_rd_acc) && w_oob) r_err_oob <= 1'b1;
      if (w_proto_acc) r_err_proto <= 1'b1;
    end
  end

  amm_rd_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (w_rd_acc),
    .i_data  (w_rd_data),
    .o_valid (w_rdv),
    .o_data  (w_rd_q)
  );

  assign avs.avs_waitrequest   = w_wait;
  assign avs.avs_readdata      = w_rd_q;
  assign avs.avs_readdatavalid = w_rdv;
  assign wr_count              = r_wr_count;
  assign rd_count              = r_rd_count;
  assign err_oob               = r_err_oob;
  assign err_proto             = r_err_proto;

endmodule
